// File: rtl/fetch_unit.sv
// fetch_unit: pipelined Wishbone read master that streams instruction words
// into a small prefetch FIFO and presents them to decode over valid/ready.
// The number of in-flight requests is limited by the FIFO space that is free, so a
// response always has room. A redirect flushes the FIFO and drops stale responses.
module fetch_unit #(
   parameter int unsigned          AddrWidth = 30,
   parameter logic [AddrWidth-1:0] ResetAddr = '0,
   parameter int unsigned          FifoDepth = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          bus_data_s,
   input  logic                 bus_ack,
   input  logic                 bus_stall,
   input  logic                 bus_err,
   output logic [31:0]          bus_data_m,
   output logic [AddrWidth-1:0] bus_addr,
   output logic [3:0]           bus_sel,
   output logic                 bus_cyc,
   output logic                 bus_stb,
   output logic                 bus_we,
   input  logic                 redirect,
   input  logic [AddrWidth-1:0] redirect_addr,
   output logic                 instr_valid,
   output logic [31:0]          instr_data,
   output logic [AddrWidth-1:0] instr_addr,
   output logic                 instr_err,
   input  logic                 instr_ready
);

   localparam int unsigned   PtrW  = $clog2(FifoDepth);
   localparam int unsigned   CntW  = $clog2(FifoDepth + 1);
   localparam logic [CntW:0] Depth = (CntW + 1)'(FifoDepth);

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                 stb;
   logic                 stb_nxt;
   logic [AddrWidth-1:0] fetch_addr;
   logic [AddrWidth-1:0] resp_addr;
   logic [CntW-1:0]      outstanding;
   logic [CntW-1:0]      outstanding_nxt;
   logic [CntW-1:0]      discard;
   logic [CntW-1:0]      fifo_count;
   logic [CntW-1:0]      fifo_count_nxt;
   logic [PtrW-1:0]      wr_ptr;
   logic [PtrW-1:0]      rd_ptr;
   logic                 credit;

   logic [31:0]          data_mem [FifoDepth];
   logic [AddrWidth-1:0] addr_mem [FifoDepth];
   logic [FifoDepth-1:0] err_mem;

   logic accept;
   logic resp;
   logic keep;
   logic pop;

   // A request is taken when strobed and not stalled; a response is ack or err
   // (err wins when both are set). A response is only ever counted against an
   // in-flight request.
   assign accept = stb & ~bus_stall;
   assign resp   = (bus_ack | bus_err) & (outstanding != '0);
   // Responses are dropped while discarding or during a redirect cycle.
   assign keep   = resp & (discard == '0) & ~redirect;
   // A pop in a redirect cycle is meaningless because the FIFO is being cleared.
   assign pop    = instr_valid & instr_ready & ~redirect;

   // Post-edge in-flight and FIFO occupancy; the next strobe is decided on these.
   always_comb begin
      outstanding_nxt = outstanding + CntW'(accept) - CntW'(resp);
      fifo_count_nxt  = redirect ? '0 : (fifo_count + CntW'(keep) - CntW'(pop));
      credit          = ({1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt}) < Depth;
   end

   // Fetch state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Redirect always restarts fetching; a kept error response halts it.
   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = FETCH;
      end else if (keep && bus_err) begin
         state_nxt = HALT;
      end
   end

   // Strobe for the next cycle: only while fetching, never right after a redirect,
   // and only when every in-flight plus buffered word still leaves a free slot.
   always_comb begin
      stb_nxt = 1'b0;
      if (!redirect && (state_nxt == FETCH)) begin
         stb_nxt = credit;
      end
   end

   // Bus-side bookkeeping: strobe, request/response addresses, in-flight and discard counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb         <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         fetch_addr  <= ResetAddr;
         resp_addr   <= ResetAddr;
      end else begin
         stb         <= stb_nxt;
         outstanding <= outstanding_nxt;
         if (redirect) begin
            // Everything still in flight after this edge is stale, including a
            // request accepted in this very cycle.
            discard    <= outstanding_nxt;
            fetch_addr <= redirect_addr;
            resp_addr  <= redirect_addr;
         end else begin
            if (resp && (discard != '0)) begin
               discard <= discard - CntW'(1);
            end
            if (accept) begin
               fetch_addr <= fetch_addr + AddrWidth'(1);
            end
            if (keep) begin
               resp_addr <= resp_addr + AddrWidth'(1);
            end
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         fifo_count <= fifo_count_nxt;
         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (keep) begin
               wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PtrW'(1);
            end
         end
      end
   end

   // FIFO storage; error entries carry zero data so no bus garbage leaks to decode.
   always_ff @(posedge clk) begin
      if (keep) begin
         data_mem[wr_ptr] <= bus_err ? 32'h0 : bus_data_s;
         addr_mem[wr_ptr] <= resp_addr;
         err_mem[wr_ptr]  <= bus_err;
      end
   end

   assign instr_valid = (fifo_count != '0);
   assign instr_data  = data_mem[rd_ptr];
   assign instr_addr  = addr_mem[rd_ptr];
   assign instr_err   = instr_valid & err_mem[rd_ptr];

   assign bus_stb    = stb;
   assign bus_addr   = fetch_addr;
   assign bus_cyc    = stb | (outstanding != '0) | (discard != '0);
   assign bus_we     = 1'b0;
   assign bus_sel    = 4'b1111;
   assign bus_data_m = 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a ROM slave model of
// selectable latency and a scoreboard of expected instruction words.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int              AW       = 30;
   localparam logic [AW-1:0]   RST_ADDR = 30'h10;

   logic            clk           = 1'b0;
   logic            rst_n         = 1'b0;
   logic [31:0]     bus_data_s    = 32'h0;
   logic            bus_ack       = 1'b0;
   logic            bus_stall     = 1'b0;
   logic            bus_err       = 1'b0;
   logic [31:0]     bus_data_m;
   logic [AW-1:0]   bus_addr;
   logic [3:0]      bus_sel;
   logic            bus_cyc;
   logic            bus_stb;
   logic            bus_we;
   logic            redirect      = 1'b0;
   logic [AW-1:0]   redirect_addr = '0;
   logic            instr_valid;
   logic [31:0]     instr_data;
   logic [AW-1:0]   instr_addr;
   logic            instr_err;
   logic            instr_ready   = 1'b1;

   fetch_unit #(
      .AddrWidth(AW),
      .ResetAddr(RST_ADDR),
      .FifoDepth(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus_data_s   (bus_data_s),
      .bus_ack      (bus_ack),
      .bus_stall    (bus_stall),
      .bus_err      (bus_err),
      .bus_data_m   (bus_data_m),
      .bus_addr     (bus_addr),
      .bus_sel      (bus_sel),
      .bus_cyc      (bus_cyc),
      .bus_stb      (bus_stb),
      .bus_we       (bus_we),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .instr_addr   (instr_addr),
      .instr_err    (instr_err),
      .instr_ready  (instr_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // slave model controls (written by the stimulus) and state (slave only)
   int            lat      = 1;
   logic          err_on   = 1'b0;
   logic [AW-1:0] err_addr = '0;
   int            req_cnt  = 0;
   logic          s_acc    = 1'b0;
   logic [AW-1:0] s_addr   = '0;
   logic          r_vld    = 1'b0;
   logic [AW-1:0] r_addr   = '0;
   logic          d_vld    = 1'b0;
   logic [AW-1:0] d_addr   = '0;

   function automatic logic [31:0] rom(input logic [AW-1:0] a);
      return {2'b01, a} ^ 32'h5A5A_0000;
   endfunction

   // ROM slave: samples the request at the edge, answers lat cycles later.
   always @(posedge clk) begin
      s_acc  = rst_n && bus_stb && !bus_stall;
      s_addr = bus_addr;
      if (s_acc) req_cnt++;
      #1;
      if (lat == 1) begin
         r_vld  = s_acc;
         r_addr = s_addr;
      end else begin
         r_vld  = d_vld;
         r_addr = d_addr;
         d_vld  = s_acc;
         d_addr = s_addr;
      end
      bus_err    = r_vld && err_on && (r_addr == err_addr);
      bus_ack    = r_vld && !bus_err;
      bus_data_s = bus_err ? 32'hBAD0_BAD0 : (r_vld ? rom(r_addr) : 32'h0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_run(input logic [AW-1:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.addr = start + AW'(i);
         e.err  = err_on && (e.addr == err_addr);
         e.data = e.err ? 32'h0 : rom(e.addr);
         sb.push_back(e);
      end
   endtask

   // Compare the head word against the scoreboard whenever it is consumed.
   task automatic monitor();
      exp_t e;
      if (rst_n && instr_valid && instr_ready && !redirect) begin
         if (sb.size() == 0) begin
            chk("extra_word", 64'(instr_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("instr_addr", 64'(instr_addr), 64'(e.addr));
            chk("instr_data", 64'(instr_data), 64'(e.data));
            chk("instr_err",  64'(instr_err),  64'(e.err));
         end
      end
   endtask

   // Advance n cycles; returns 2 time units after a rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         monitor();
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] hold;
      int            base;

      // reset state
      step(2);
      chk("rst_cyc",    64'(bus_cyc),     64'd0);
      chk("rst_stb",    64'(bus_stb),     64'd0);
      chk("rst_valid",  64'(instr_valid), 64'd0);
      chk("rst_err",    64'(instr_err),   64'd0);
      chk("const_we",   64'(bus_we),      64'd0);
      chk("const_sel",  64'(bus_sel),     64'hF);
      chk("const_dm",   64'(bus_data_m),  64'd0);

      // streaming from ResetAddr with a zero-wait slave
      push_run(RST_ADDR, 64);
      rst_n = 1'b1;
      step(1);
      chk("first_stb",  64'(bus_stb),     64'd1);
      chk("first_addr", 64'(bus_addr),    64'h10);
      step(1);
      chk("lat_valid2", 64'(instr_valid), 64'd0);
      step(1);
      chk("lat_valid3", 64'(instr_valid), 64'd1);
      chk("lat_addr3",  64'(instr_addr),  64'h10);
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("stream_valid", 64'(instr_valid), 64'd1);
      end

      // three stalled cycles mid-stream
      hold = bus_addr;
      chk("pre_stall_stb", 64'(bus_stb), 64'd1);
      bus_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("stall_addr", 64'(bus_addr), 64'(hold));
         chk("stall_stb",  64'(bus_stb),  64'd1);
      end
      bus_stall = 1'b0;
      step(6);

      // asynchronous reset mid-burst with acks pending
      rst_n = 1'b0;
      #1;
      chk("arst_cyc",   64'(bus_cyc),     64'd0);
      chk("arst_stb",   64'(bus_stb),     64'd0);
      chk("arst_valid", 64'(instr_valid), 64'd0);
      sb.delete();
      step(2);

      // consumer stalled: exactly FifoDepth requests, then strobe stops
      instr_ready = 1'b0;
      push_run(RST_ADDR, 40);
      rst_n = 1'b1;
      base  = req_cnt;
      chk("rel_valid", 64'(instr_valid), 64'd0);
      step(1);
      chk("rel_addr", 64'(bus_addr), 64'h10);
      chk("rel_stb",  64'(bus_stb),  64'd1);
      step(19);
      chk("full_reqs",  64'(req_cnt - base), 64'd4);
      chk("full_stb",   64'(bus_stb),        64'd0);
      chk("full_cyc",   64'(bus_cyc),        64'd0);
      chk("full_valid", 64'(instr_valid),    64'd1);
      chk("full_head",  64'(instr_addr),     64'h10);
      instr_ready = 1'b1;
      step(12);

      // redirect with responses in flight and words buffered
      lat = 2;
      step(4);
      instr_ready   = 1'b0;
      step(1);
      redirect      = 1'b1;
      redirect_addr = 30'h200;
      sb.delete();
      push_run(30'h200, 40);
      step(1);
      redirect = 1'b0;
      chk("redir_valid", 64'(instr_valid), 64'd0);
      chk("redir_stb",   64'(bus_stb),     64'd0);
      chk("redir_cyc",   64'(bus_cyc),     64'd1);
      step(1);
      chk("redir_stb2",  64'(bus_stb),     64'd1);
      chk("redir_addr",  64'(bus_addr),    64'h200);
      instr_ready = 1'b1;
      step(15);

      // error response halts fetching until the next redirect
      instr_ready   = 1'b0;
      err_on        = 1'b1;
      err_addr      = 30'h303;
      redirect      = 1'b1;
      redirect_addr = 30'h300;
      sb.delete();
      push_run(30'h300, 4);
      step(1);
      redirect = 1'b0;
      base     = req_cnt;
      step(15);
      chk("err_reqs",  64'(req_cnt - base), 64'd4);
      chk("err_stb",   64'(bus_stb),        64'd0);
      chk("err_valid", 64'(instr_valid),    64'd1);
      chk("err_head",  64'(instr_addr),     64'h300);
      instr_ready = 1'b1;
      step(8);
      chk("halt_drained", 64'(sb.size()),      64'd0);
      chk("halt_stb",     64'(bus_stb),        64'd0);
      chk("halt_cyc",     64'(bus_cyc),        64'd0);
      chk("halt_valid",   64'(instr_valid),    64'd0);
      chk("halt_reqs",    64'(req_cnt - base), 64'd4);

      // redirect out of the halt
      err_on        = 1'b0;
      redirect      = 1'b1;
      redirect_addr = 30'h0;
      sb.delete();
      push_run(30'h0, 20);
      step(1);
      redirect = 1'b0;
      step(1);
      chk("resume_stb",  64'(bus_stb),  64'd1);
      chk("resume_addr", 64'(bus_addr), 64'h0);
      step(10);
      chk("resume_valid", 64'(instr_valid), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
